// File: rtl/fastram_sdio_cycle_ctrl.sv
// Decodes 68000 bus cycles against the autoconfig bases and runs either an SRAM
// cycle with wait states or an SDIO request/ack handshake with a timeout.
module fastram_sdio_cycle_ctrl #(
  parameter int RAM_WAIT     = 1,
  parameter int SDIO_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AS_CPU_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW_n,
  input  logic [7:0] A_HIGH,
  input  logic       JP4,
  input  logic [2:0] BASE_RAM,
  input  logic [7:0] BASE_SDIO,
  input  logic       RAM_CONFIGURED_n,
  input  logic       SDIO_CONFIGURED_n,
  input  logic       SDIO_ACK,
  output logic       RAM_CE_n,
  output logic       RAM_OE_n,
  output logic [1:0] RAM_WE_n,
  output logic       SDIO_REQ,
  output logic       DTACK_n,
  output logic       BERR_n
);

  // state   | meaning
  // IDLE    | waiting for a new address strobe, decode runs here
  // RAM     | SRAM strobes active, counting wait states
  // SREQ    | one-cycle SDIO request pulse
  // SWAIT   | waiting for SDIO_ACK, timeout timer running
  // ACK     | DTACK_n held until the CPU drops AS
  // BERR    | BERR_n held until the CPU drops AS
  // RELEASE | cycle not ours, wait for AS to go away
  typedef enum logic [2:0] {
    S_IDLE, S_RAM, S_SREQ, S_SWAIT, S_ACK, S_BERR, S_RELEASE
  } state_e;

  localparam logic [3:0] RAM_WAIT_C = 4'(RAM_WAIT);
  localparam logic [7:0] TIMEOUT_C  = 8'(SDIO_TIMEOUT);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tmr_q, tmr_d;
  logic [2:0] meta_q, sync_q;
  logic       ram_ce_n_q, ram_ce_n_d;
  logic       ram_oe_n_q, ram_oe_n_d;
  logic [1:0] ram_we_n_q, ram_we_n_d;
  logic       sdio_req_q, sdio_req_d;
  logic       dtack_n_q, dtack_n_d;
  logic       berr_n_q, berr_n_d;
  logic       as_s, uds_s, lds_s;
  logic       ram_hit, sdio_hit;

  assign as_s  = sync_q[2];
  assign uds_s = sync_q[1];
  assign lds_s = sync_q[0];

  assign ram_hit  = !RAM_CONFIGURED_n &&
                    (JP4 ? (A_HIGH[7] == BASE_RAM[2]) : (A_HIGH[7:6] == BASE_RAM[2:1]));
  assign sdio_hit = !SDIO_CONFIGURED_n && (A_HIGH == BASE_SDIO);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tmr_q      <= '0;
      meta_q     <= 3'b111;
      sync_q     <= 3'b111;
      ram_ce_n_q <= 1'b1;
      ram_oe_n_q <= 1'b1;
      ram_we_n_q <= 2'b11;
      sdio_req_q <= 1'b0;
      dtack_n_q  <= 1'b1;
      berr_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      meta_q     <= {AS_CPU_n, UDS_n, LDS_n};
      sync_q     <= meta_q;
      ram_ce_n_q <= ram_ce_n_d;
      ram_oe_n_q <= ram_oe_n_d;
      ram_we_n_q <= ram_we_n_d;
      sdio_req_q <= sdio_req_d;
      dtack_n_q  <= dtack_n_d;
      berr_n_q   <= berr_n_d;
    end
  end

  // Every exit from a cycle requires as_s high, so a cycle is never decoded twice.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (!as_s) begin
          if (ram_hit) begin
            state_d = S_RAM;
            cnt_d   = RAM_WAIT_C;
          end else if (sdio_hit) begin
            state_d = S_SREQ;
          end else begin
            state_d = S_RELEASE;
          end
        end
      end
      S_RAM: begin
        if (as_s)              state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_ACK;
        else                   cnt_d   = cnt_q - 4'd1;
      end
      S_SREQ: begin
        if (as_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SWAIT;
          tmr_d   = TIMEOUT_C;
        end
      end
      S_SWAIT: begin
        if (as_s)              state_d = S_IDLE;
        else if (SDIO_ACK)     state_d = S_ACK;
        else if (tmr_q == '0)  state_d = S_BERR;
        else                   tmr_d   = tmr_q - 8'd1;
      end
      S_ACK, S_BERR, S_RELEASE: begin
        if (as_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ram_ce_n_d = ram_ce_n_q;
    ram_oe_n_d = ram_oe_n_q;
    ram_we_n_d = ram_we_n_q;
    sdio_req_d = 1'b0;
    dtack_n_d  = dtack_n_q;
    berr_n_d   = berr_n_q;
    if (state_d == S_IDLE) begin
      ram_ce_n_d = 1'b1;
      ram_oe_n_d = 1'b1;
      ram_we_n_d = 2'b11;
      dtack_n_d  = 1'b1;
      berr_n_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (state_d == S_RAM) begin
            ram_ce_n_d = 1'b0;
            ram_oe_n_d = !RW_n;
            ram_we_n_d = {RW_n | uds_s, RW_n | lds_s};
          end else if (state_d == S_SREQ) begin
            sdio_req_d = 1'b1;
          end
        end
        // Data strobes trail AS on writes, so byte enables track them live.
        S_RAM: begin
          ram_we_n_d = {RW_n | uds_s, RW_n | lds_s};
          if (state_d == S_ACK) dtack_n_d = 1'b0;
        end
        S_SWAIT: begin
          if (state_d == S_ACK)  dtack_n_d = 1'b0;
          if (state_d == S_BERR) berr_n_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign RAM_CE_n = ram_ce_n_q;
  assign RAM_OE_n = ram_oe_n_q;
  assign RAM_WE_n = ram_we_n_q;
  assign SDIO_REQ = sdio_req_q;
  assign DTACK_n  = dtack_n_q;
  assign BERR_n   = berr_n_q;

endmodule

// File: tb/tb_fastram_sdio_cycle_ctrl.sv
// Directed bench: two instances share the bus, one with default parameters and one
// with zero RAM wait states and a short SDIO timeout.
module tb_fastram_sdio_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       RESET, AS_CPU_n, UDS_n, LDS_n, RW_n, JP4, SDIO_ACK;
  logic       RAM_CONFIGURED_n, SDIO_CONFIGURED_n;
  logic [7:0] A_HIGH, BASE_SDIO;
  logic [2:0] BASE_RAM;

  logic       a_ce, a_oe, a_req, a_dtack, a_berr;
  logic [1:0] a_we;
  logic       b_ce, b_oe, b_req, b_dtack, b_berr;
  logic [1:0] b_we;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fastram_sdio_cycle_ctrl #(.RAM_WAIT(1), .SDIO_TIMEOUT(255)) dut_a (
    .CLK(CLK), .RESET(RESET), .AS_CPU_n(AS_CPU_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
    .RW_n(RW_n), .A_HIGH(A_HIGH), .JP4(JP4), .BASE_RAM(BASE_RAM), .BASE_SDIO(BASE_SDIO),
    .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .SDIO_CONFIGURED_n(SDIO_CONFIGURED_n),
    .SDIO_ACK(SDIO_ACK), .RAM_CE_n(a_ce), .RAM_OE_n(a_oe), .RAM_WE_n(a_we),
    .SDIO_REQ(a_req), .DTACK_n(a_dtack), .BERR_n(a_berr));

  fastram_sdio_cycle_ctrl #(.RAM_WAIT(0), .SDIO_TIMEOUT(4)) dut_b (
    .CLK(CLK), .RESET(RESET), .AS_CPU_n(AS_CPU_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
    .RW_n(RW_n), .A_HIGH(A_HIGH), .JP4(JP4), .BASE_RAM(BASE_RAM), .BASE_SDIO(BASE_SDIO),
    .RAM_CONFIGURED_n(RAM_CONFIGURED_n), .SDIO_CONFIGURED_n(SDIO_CONFIGURED_n),
    .SDIO_ACK(SDIO_ACK), .RAM_CE_n(b_ce), .RAM_OE_n(b_oe), .RAM_WE_n(b_we),
    .SDIO_REQ(b_req), .DTACK_n(b_dtack), .BERR_n(b_berr));

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_cycle(input logic [7:0] addr, input logic rw,
                             input logic uds, input logic lds);
    A_HIGH   = addr;
    RW_n     = rw;
    UDS_n    = uds;
    LDS_n    = lds;
    AS_CPU_n = 1'b0;
  endtask

  task automatic end_cycle();
    AS_CPU_n = 1'b1;
    UDS_n    = 1'b1;
    LDS_n    = 1'b1;
  endtask

  initial begin
    RESET = 1'b1; AS_CPU_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW_n = 1'b1;
    A_HIGH = 8'h00; JP4 = 1'b1; BASE_RAM = 3'b001; BASE_SDIO = 8'h00;
    RAM_CONFIGURED_n = 1'b0; SDIO_CONFIGURED_n = 1'b1; SDIO_ACK = 1'b0;
    tick(2);
    chk("rst_ce", {7'd0, a_ce}, 8'h01);
    chk("rst_we", {6'd0, a_we}, 8'h03);
    chk("rst_dtack_berr_req", {5'd0, a_dtack, a_berr, a_req}, 8'h06);
    RESET = 1'b0;
    tick(2);

    // 8 MB read hit at 0x30
    start_cycle(8'h30, 1'b1, 1'b0, 1'b0);
    tick(2);
    chk("rd_ce_early", {7'd0, a_ce}, 8'h01);
    tick(1);
    chk("rd_ce", {7'd0, a_ce}, 8'h00);
    chk("rd_oe", {7'd0, a_oe}, 8'h00);
    chk("rd_we", {6'd0, a_we}, 8'h03);
    chk("rd_dtack_t3", {7'd0, a_dtack}, 8'h01);
    tick(1);
    chk("rd_dtack_t4", {7'd0, a_dtack}, 8'h01);
    chk("rd_b_wait0_dtack", {7'd0, b_dtack}, 8'h00);
    tick(1);
    chk("rd_dtack_t5", {7'd0, a_dtack}, 8'h00);
    end_cycle();
    tick(2);
    chk("rd_dtack_hold", {7'd0, a_dtack}, 8'h00);
    tick(1);
    chk("rd_release", {5'd0, a_dtack, a_ce, a_oe}, 8'h07);
    tick(2);

    // 8 MB read miss at 0x90
    start_cycle(8'h90, 1'b1, 1'b0, 1'b0);
    tick(6);
    chk("rd_miss", {4'd0, a_ce, a_dtack, b_ce, b_dtack}, 8'h0f);
    end_cycle();
    tick(3);

    // 4 MB write at 0x40, only LDS, strobe arrives one cycle after AS
    JP4 = 1'b0; BASE_RAM = 3'b010;
    start_cycle(8'h40, 1'b0, 1'b1, 1'b1);
    tick(1);
    LDS_n = 1'b0;
    tick(2);
    chk("wr_ce", {7'd0, a_ce}, 8'h00);
    chk("wr_oe", {7'd0, a_oe}, 8'h01);
    chk("wr_we_early", {6'd0, a_we}, 8'h03);
    tick(1);
    chk("wr_we", {6'd0, a_we}, 8'h02);
    chk("wr_b_we", {6'd0, b_we}, 8'h02);
    tick(1);
    chk("wr_dtack", {7'd0, a_dtack}, 8'h00);
    end_cycle();
    tick(3);
    chk("wr_release_we", {6'd0, a_we}, 8'h03);

    // 4 MB miss at 0x80
    start_cycle(8'h80, 1'b0, 1'b1, 1'b0);
    tick(6);
    chk("wr_miss", {4'd0, a_ce, a_we, a_dtack}, 8'h0f);
    end_cycle();
    tick(3);

    // SDIO hit at 0xE9; dut_b times out, dut_a is acked later
    BASE_SDIO = 8'hE9; SDIO_CONFIGURED_n = 1'b0;
    start_cycle(8'hE9, 1'b1, 1'b0, 1'b0);
    tick(3);
    chk("sd_req", {5'd0, a_req, b_req, a_ce}, 8'h07);
    tick(1);
    chk("sd_req_pulse", {6'd0, a_req, b_req}, 8'h00);
    tick(4);
    chk("sd_b_berr_t8", {7'd0, b_berr}, 8'h01);
    tick(1);
    chk("sd_b_berr_t9", {6'd0, b_berr, b_dtack}, 8'h01);
    tick(4);
    chk("sd_a_wait", {6'd0, a_dtack, a_berr}, 8'h03);
    SDIO_ACK = 1'b1;
    tick(1);
    SDIO_ACK = 1'b0;
    chk("sd_a_dtack", {6'd0, a_dtack, a_berr}, 8'h01);
    chk("sd_b_late_ack", {6'd0, b_dtack, b_berr}, 8'h02);
    end_cycle();
    tick(3);
    chk("sd_release", {6'd0, a_dtack, b_berr}, 8'h03);

    // ACK on the same edge the timer expires
    start_cycle(8'hE9, 1'b1, 1'b0, 1'b0);
    tick(8);
    SDIO_ACK = 1'b1;
    tick(1);
    SDIO_ACK = 1'b0;
    chk("sd_ack_vs_to", {6'd0, b_dtack, b_berr}, 8'h01);
    end_cycle();
    tick(3);
    chk("sd_ack_vs_to_rel", {7'd0, b_dtack}, 8'h01);

    // Both hit: RAM wins
    JP4 = 1'b1; BASE_RAM = 3'b111;
    start_cycle(8'hE9, 1'b1, 1'b0, 1'b0);
    tick(3);
    chk("prio_ram", {6'd0, a_ce, a_req}, 8'h00);
    tick(2);
    chk("prio_dtack", {7'd0, a_dtack}, 8'h00);
    end_cycle();
    tick(3);

    // RAM unconfigured: SDIO runs, then CPU aborts during SWAIT
    RAM_CONFIGURED_n = 1'b1;
    start_cycle(8'hE9, 1'b1, 1'b0, 1'b0);
    tick(3);
    chk("unc_ram_sdio", {6'd0, a_req, a_ce}, 8'h03);
    tick(2);
    end_cycle();
    tick(3);
    chk("abort_idle", {3'd0, a_req, a_dtack, a_berr, a_ce, b_berr}, 8'h0f);
    tick(1);
    chk("abort_no_to", {7'd0, b_berr}, 8'h01);
    SDIO_ACK = 1'b1;
    tick(1);
    SDIO_ACK = 1'b0;
    tick(2);
    chk("abort_late_ack", {6'd0, a_dtack, b_dtack}, 8'h03);

    // Reset while in ACK
    RAM_CONFIGURED_n = 1'b0;
    start_cycle(8'hE9, 1'b1, 1'b0, 1'b0);
    tick(5);
    chk("rst_pre_ack", {7'd0, a_dtack}, 8'h00);
    RESET = 1'b1;
    tick(1);
    chk("rst_in_ack", {6'd0, a_dtack, a_ce}, 8'h03);
    end_cycle();
    tick(3);
    RESET = 1'b0;
    tick(4);
    chk("rst_after", {6'd0, a_dtack, a_ce}, 8'h03);

    // Unconfigured bases at zero never hit
    RAM_CONFIGURED_n = 1'b1; SDIO_CONFIGURED_n = 1'b1;
    BASE_RAM = 3'b000; BASE_SDIO = 8'h00;
    start_cycle(8'h00, 1'b1, 1'b0, 1'b0);
    tick(3);
    chk("unc_zero_t3", {6'd0, a_req, b_ce}, 8'h01);
    tick(3);
    chk("unc_zero_t6", {5'd0, a_ce, a_dtack, a_berr}, 8'h07);
    end_cycle();
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
